// File: rtl/ram_responder_if.sv
// ram_responder_if: request/acknowledge bus between the RAM initiator and the
// RAM responder.
//   ramAddress  byte address of the access (initiator -> responder)
//   ramOut      write data (initiator -> responder)
//   readReq     read request (initiator -> responder)
//   writeReq    write request (initiator -> responder)
//   ramIn       read data (responder -> initiator)
//   readAck     one-cycle read acknowledge (responder -> initiator)
//   writeAck    one-cycle write acknowledge (responder -> initiator)
interface ram_responder_if;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic [31:0] ramIn;
  logic        readAck;
  logic        writeAck;

  modport master (
    output ramAddress, ramOut, readReq, writeReq,
    input  ramIn, readAck, writeAck
  );

  modport slave (
    input  ramAddress, ramOut, readReq, writeReq,
    output ramIn, readAck, writeAck
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the CPU RAM request/acknowledge
// bus. Services single-word reads and writes against an internal word array
// after LATENCY wait cycles, and offers a side load port for preloading.
//   clk       rising-edge clock
//   reset     synchronous, active-low reset (array contents are kept)
//   bus       ram_responder_if.slave request/acknowledge bus
//   loadEn    side-port write enable (any state, never acknowledged)
//   loadAddr  side-port byte address
//   loadData  side-port write data
//   busy      high from request capture until the edge the ack falls
//   errors    sticky: [0] protocol error, [1] out-of-range access
module ram_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] OOR_READ   = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_responder_if.slave        bus,
  input  logic                  loadEn,
  input  logic [31:0]           loadAddr,
  input  logic [31:0]           loadData,
  output logic                  busy,
  output logic [1:0]            errors
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [31:0]             req_addr;
  logic [31:0]             req_data;
  logic                    req_write;
  logic [31:0]             mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [DEPTH_LOG2-1:0]   load_idx;
  logic                    req_in_range;
  logic                    load_in_range;
  logic                    any_req;
  logic                    commit_we;
  logic                    load_we;

  // An address is in range when no bit above the word index is set.
  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> (DEPTH_LOG2 + 2)) == 32'd0;
  endfunction

  assign req_idx       = req_addr[DEPTH_LOG2+1:2];
  assign load_idx      = loadAddr[DEPTH_LOG2+1:2];
  assign req_in_range  = in_range(req_addr);
  assign load_in_range = in_range(loadAddr);
  assign any_req       = bus.readReq || bus.writeReq;

  // A write commit is suppressed while reset is low so that a request
  // pending at reset is dropped entirely.
  assign commit_we = reset && (state == RESP) && req_write && req_in_range;
  assign load_we   = loadEn && load_in_range;

  // NOTE: the array has no reset; clearing it would need a per-word reset
  // tree and would also destroy preloaded contents that must survive reset.
  // The commit assignment comes last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (load_we)   mem[load_idx] <= loadData;
    if (commit_we) mem[req_idx]  <= req_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      busy         <= 1'b0;
      errors       <= '0;
      bus.readAck  <= 1'b0;
      bus.writeAck <= 1'b0;
      bus.ramIn    <= '0;
    end else begin
      // Acks are single-cycle pulses: cleared every edge unless RESP sets them.
      bus.readAck  <= 1'b0;
      bus.writeAck <= 1'b0;

      if (loadEn && !load_in_range) errors[1] <= 1'b1;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (any_req) begin
            req_addr  <= bus.ramAddress;
            req_data  <= bus.ramOut;
            // A simultaneous read+write is serviced as the write.
            req_write <= bus.writeReq;
            busy      <= 1'b1;
            wait_cnt  <= 4'(LATENCY);
            state     <= WAIT;
            if (bus.readReq && bus.writeReq) errors[0] <= 1'b1;
          end
        end

        WAIT: begin
          if (any_req) errors[0] <= 1'b1;
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end

        RESP: begin
          if (any_req)       errors[0] <= 1'b1;
          if (!req_in_range) errors[1] <= 1'b1;
          if (req_write) begin
            bus.writeAck <= 1'b1;
          end else begin
            bus.readAck <= 1'b1;
            bus.ramIn   <= req_in_range ? mem[req_idx] : OOR_READ;
          end
          // Back in IDLE on the ack edge, so busy falls and a new request
          // can be captured on the edge the ack falls.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed bench for ram_responder. The main instance uses
// LATENCY=1; two extra instances (LATENCY=0 and LATENCY=4) share the same
// stimulus and are used for the latency/busy timing checks.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadEn;
  logic [31:0] loadAddr;
  logic [31:0] loadData;
  logic        busy, busy0, busy4;
  logic [1:0]  errors, errors0, errors4;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q [$];

  // latency-step bookkeeping: first ack edge, ack count, first busy-low edge
  int f1, f0, f4, n1, n0, n4, z1, z0, z4;
  int nr, nw;

  always #5 clk = ~clk;

  ram_responder_if bus ();
  ram_responder_if bus0 ();
  ram_responder_if bus4 ();

  assign bus0.ramAddress = bus.ramAddress;
  assign bus0.ramOut     = bus.ramOut;
  assign bus0.readReq    = bus.readReq;
  assign bus0.writeReq   = bus.writeReq;
  assign bus4.ramAddress = bus.ramAddress;
  assign bus4.ramOut     = bus.ramOut;
  assign bus4.readReq    = bus.readReq;
  assign bus4.writeReq   = bus.writeReq;

  ram_responder #(.LATENCY(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .loadEn(loadEn),
    .loadAddr(loadAddr), .loadData(loadData), .busy(busy), .errors(errors)
  );

  ram_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .loadEn(loadEn),
    .loadAddr(loadAddr), .loadData(loadData), .busy(busy0), .errors(errors0)
  );

  ram_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .loadEn(loadEn),
    .loadAddr(loadAddr), .loadData(loadData), .busy(busy4), .errors(errors4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    loadEn   = 1'b1;
    loadAddr = addr;
    loadData = data;
    tick();
    loadEn   = 1'b0;
  endtask

  // Present a request for exactly one edge (the capture edge).
  task automatic pulse_req(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data);
    bus.readReq    = rd;
    bus.writeReq   = wr;
    bus.ramAddress = addr;
    bus.ramOut     = data;
    tick();
    bus.readReq    = 1'b0;
    bus.writeReq   = 1'b0;
  endtask

  // Wait (bounded) for an ack on the main instance; an expired bound fails.
  task automatic wait_ack(output int edges, output logic got_r, output logic got_w);
    logic found;
    found = 1'b0;
    edges = 0;
    got_r = 1'b0;
    got_w = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (bus.readAck || bus.writeAck) begin
        found = 1'b1;
        edges = i;
        got_r = bus.readAck;
        got_w = bus.writeAck;
      end
    end
    check("ack_seen", 32'(found), 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int   e;
    logic r, w;
    exp_q.push_back(exp);
    pulse_req(1'b1, 1'b0, addr, 32'h0);
    wait_ack(e, r, w);
    check({tag, "_rack"}, 32'(r), 32'd1);
    check({tag, "_nowack"}, 32'(w), 32'd0);
    if (r && exp_q.size() > 0) check({tag, "_data"}, bus.ramIn, exp_q.pop_front());
    tick();
    check({tag, "_ackfall"}, 32'(bus.readAck), 32'd0);
    repeat (6) tick();   // let the slower copies drain
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    int   e;
    logic r, w;
    pulse_req(1'b0, 1'b1, addr, data);
    wait_ack(e, r, w);
    check({tag, "_wack"}, 32'(w), 32'd1);
    check({tag, "_norack"}, 32'(r), 32'd0);
    tick();
    check({tag, "_ackfall"}, 32'(bus.writeAck), 32'd0);
    repeat (6) tick();
  endtask

  initial begin
    reset          = 1'b0;
    loadEn         = 1'b0;
    loadAddr       = '0;
    loadData       = '0;
    bus.readReq    = 1'b0;
    bus.writeReq   = 1'b0;
    bus.ramAddress = '0;
    bus.ramOut     = '0;

    // Reset state
    repeat (2) tick();
    check("rst_ramIn", bus.ramIn, 32'h0);
    check("rst_rack", 32'(bus.readAck), 32'd0);
    check("rst_wack", 32'(bus.writeAck), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errors", 32'(errors), 32'd0);
    reset = 1'b1;
    tick();

    load_word(32'd8, 32'h12345678);   // word 2
    load_word(32'd0, 32'hA5A5A5A5);   // word 0

    // Latency and busy window on all three instances from one capture edge.
    f1 = 0; f0 = 0; f4 = 0; n1 = 0; n0 = 0; n4 = 0; z1 = 0; z0 = 0; z4 = 0;
    pulse_req(1'b1, 1'b0, 32'd8, 32'h0);
    check("cap_busy1", 32'(busy), 32'd1);
    check("cap_busy0", 32'(busy0), 32'd1);
    check("cap_busy4", 32'(busy4), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.readAck)  begin if (f1 == 0) f1 = i; n1++; end
      if (bus0.readAck) begin if (f0 == 0) f0 = i; n0++; end
      if (bus4.readAck) begin if (f4 == 0) f4 = i; n4++; end
      if (!busy  && z1 == 0) z1 = i;
      if (!busy0 && z0 == 0) z0 = i;
      if (!busy4 && z4 == 0) z4 = i;
    end
    check("lat1_edge", 32'(f1), 32'd3);
    check("lat0_edge", 32'(f0), 32'd2);
    check("lat4_edge", 32'(f4), 32'd6);
    check("lat1_count", 32'(n1), 32'd1);
    check("lat0_count", 32'(n0), 32'd1);
    check("lat4_count", 32'(n4), 32'd1);
    check("lat1_busyoff", 32'(z1), 32'd4);
    check("lat0_busyoff", 32'(z0), 32'd3);
    check("lat4_busyoff", 32'(z4), 32'd7);
    check("hold_ramIn1", bus.ramIn, 32'h12345678);
    check("hold_ramIn0", bus0.ramIn, 32'h12345678);
    check("hold_ramIn4", bus4.ramIn, 32'h12345678);

    // Write then read with ignored low address bits.
    do_write("wr12", 32'd12, 32'hCAFEF00D);
    do_read("rd13", 32'd13, 32'hCAFEF00D);
    check("errors_clean", 32'(errors), 32'd0);

    // Out-of-range read and write; the write must not alias onto word 0.
    do_read("oor_rd", 32'h400, 32'hDEADBEEF);
    check("oor_errors", 32'(errors), 32'd2);
    do_write("oor_wr", 32'h400, 32'h11111111);
    do_read("word0_intact", 32'd0, 32'hA5A5A5A5);

    // Read and write together: serviced as write, protocol error flagged.
    nr = 0; nw = 0;
    pulse_req(1'b1, 1'b1, 32'd0, 32'h5);
    bus.readReq = 1'b1;                // second request while busy
    tick();
    bus.readReq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.readAck)  nr++;
      if (bus.writeAck) nw++;
    end
    check("both_wacks", 32'(nw), 32'd1);
    check("both_racks", 32'(nr), 32'd0);
    check("both_errors", 32'(errors), 32'd3);
    do_read("word0_five", 32'd0, 32'h5);

    // Load and write commit to the same word on the same edge: commit wins.
    pulse_req(1'b0, 1'b1, 32'd16, 32'h33);
    tick();
    tick();
    loadEn   = 1'b1;
    loadAddr = 32'd16;
    loadData = 32'h44;
    tick();
    loadEn   = 1'b0;
    check("coll_wack", 32'(bus.writeAck), 32'd1);
    repeat (6) tick();
    do_read("coll_word", 32'd16, 32'h33);

    // Reset during WAIT: request is dropped, outputs cleared, array kept.
    pulse_req(1'b1, 1'b0, 32'd8, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    nr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.readAck || bus.writeAck) nr++;
    end
    check("rstwait_noack", 32'(nr), 32'd0);
    check("rstwait_ramIn", bus.ramIn, 32'h0);
    check("rstwait_busy", 32'(busy), 32'd0);
    check("rstwait_errors", 32'(errors), 32'd0);
    do_read("after_rst_w2", 32'd8, 32'h12345678);
    do_read("after_rst_w0", 32'd0, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
